// File: rtl/mastermind_pkg.sv
// Shared types and width helpers for the Mastermind game engine.
package mastermind_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PLAY   = 3'd1,
        ST_EXACT  = 3'd2,
        ST_MATCH  = 3'd3,
        ST_REPORT = 3'd4,
        ST_WON    = 3'd5,
        ST_LOST   = 3'd6
    } state_e;

    localparam int DEFAULT_TICK_DIV = 50_000_000;

    // Bits needed to hold a count in 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Bits needed to index n items (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mastermind_tick_divider.sv
// Countdown-rate divider: one-cycle tick every DIV cycles, restarted by clr_i.
// Free-running, no backpressure; clr_i in the same cycle suppresses the tick.
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    // Zero is the reload state, so a cleared divider waits a full DIV cycles.
    always_comb begin
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            cnt_d = CW'(DIV - 1);
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clr_i && (cnt_q == CW'(1));

endmodule

// File: rtl/mastermind_core.sv
// Mastermind engine: scores a guess in SLOTS+2 cycles (exact pass, one MATCH cycle per slot).
// Guesses are only accepted in PLAY with time left; load_secret restarts the game from any state.
module mastermind_core
    import mastermind_pkg::*;
#(
    parameter int SLOTS      = 4,
    parameter int SYM_W      = 4,
    parameter int MAX_TRIES  = 10,
    parameter int TIME_LIMIT = 99,
    parameter int TICK_DIV   = DEFAULT_TICK_DIV
) (
    input  logic                            CLOCK_50,
    input  logic                            reset_n,
    input  logic                            load_secret,
    input  logic [SLOTS*SYM_W-1:0]          secret,
    input  logic                            guess_valid,
    input  logic [SLOTS*SYM_W-1:0]          guess,
    output logic                            guess_ready,
    output logic                            score_valid,
    output logic [cnt_w(SLOTS)-1:0]         exact,
    output logic [cnt_w(SLOTS)-1:0]         partial,
    output logic [3:0]                      tries_left,
    output logic [cnt_w(TIME_LIMIT)-1:0]    time_left,
    output logic                            won,
    output logic                            lost,
    output logic [2:0]                      state
);

    localparam int CNT_W  = cnt_w(SLOTS);
    localparam int TIME_W = cnt_w(TIME_LIMIT);
    localparam int IDX_W  = idx_w(SLOTS);

    state_e                 state_q, state_d;
    logic [SLOTS*SYM_W-1:0] secret_q, secret_d;
    logic [SLOTS*SYM_W-1:0] guess_q, guess_d;
    logic [SLOTS-1:0]       m_q, m_d;
    logic [SLOTS-1:0]       u_q, u_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       exact_q, exact_d;
    logic [CNT_W-1:0]       partial_q, partial_d;
    logic [3:0]             tries_q, tries_d;
    logic [TIME_W-1:0]      time_q, time_d;
    logic                   won_q, won_d;
    logic                   lost_q, lost_d;

    logic                   tick;
    logic                   clr_div;
    logic                   timed;
    logic [SYM_W-1:0]       sec_s [SLOTS];
    logic [SYM_W-1:0]       gue_s [SLOTS];
    logic [SLOTS-1:0]       exact_m;
    logic [CNT_W-1:0]       exact_cnt;
    logic [SLOTS-1:0]       hit;
    logic                   found;

    tick_divider #(.DIV(TICK_DIV)) u_div (
        .clk_i  (CLOCK_50),
        .rst_ni (reset_n),
        .clr_i  (clr_div),
        .tick_o (tick)
    );

    always_comb begin
        exact_m   = '0;
        exact_cnt = '0;
        for (int i = 0; i < SLOTS; i++) begin
            sec_s[i]   = secret_q[i*SYM_W +: SYM_W];
            gue_s[i]   = guess_q[i*SYM_W +: SYM_W];
            exact_m[i] = (sec_s[i] == gue_s[i]);
            exact_cnt  = exact_cnt + CNT_W'(exact_m[i]);
        end
    end

    // Lowest free secret slot holding the current guess symbol, one-hot.
    always_comb begin
        hit   = '0;
        found = 1'b0;
        for (int j = 0; j < SLOTS; j++) begin
            if (!found && !m_q[j] && !u_q[j] && (sec_s[j] == gue_s[idx_q])) begin
                found  = 1'b1;
                hit[j] = 1'b1;
            end
        end
    end

    assign timed       = (state_q == ST_PLAY) || (state_q == ST_EXACT) ||
                         (state_q == ST_MATCH) || (state_q == ST_REPORT);
    assign guess_ready = (state_q == ST_PLAY) && (time_q != '0) && !load_secret;

    always_comb begin
        state_d   = state_q;
        secret_d  = secret_q;
        guess_d   = guess_q;
        m_d       = m_q;
        u_d       = u_q;
        idx_d     = idx_q;
        exact_d   = exact_q;
        partial_d = partial_q;
        tries_d   = tries_q;
        time_d    = time_q;
        won_d     = won_q;
        lost_d    = lost_q;
        clr_div   = 1'b0;

        if (tick && timed && (time_q != '0)) begin
            time_d = time_q - 1'b1;
        end

        case (state_q)
            ST_PLAY: begin
                if (guess_valid && guess_ready) begin
                    guess_d   = guess;
                    tries_d   = tries_q - 1'b1;
                    exact_d   = '0;
                    partial_d = '0;
                    state_d   = ST_EXACT;
                end else if (time_q == '0) begin
                    lost_d  = 1'b1;
                    state_d = ST_LOST;
                end
            end
            ST_EXACT: begin
                m_d     = exact_m;
                exact_d = exact_cnt;
                u_d     = '0;
                idx_d   = '0;
                state_d = ST_MATCH;
            end
            ST_MATCH: begin
                if (!m_q[idx_q] && found) begin
                    u_d       = u_q | hit;
                    partial_d = partial_q + 1'b1;
                end
                if (idx_q == IDX_W'(SLOTS - 1)) begin
                    state_d = ST_REPORT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_REPORT: begin
                // A full match wins even if the clock ran out during scoring.
                if (exact_q == CNT_W'(SLOTS)) begin
                    won_d   = 1'b1;
                    state_d = ST_WON;
                end else if ((tries_q == '0) || (time_q == '0)) begin
                    lost_d  = 1'b1;
                    state_d = ST_LOST;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            default: ;
        endcase

        if (load_secret) begin
            secret_d  = secret;
            tries_d   = 4'(MAX_TRIES);
            time_d    = TIME_W'(TIME_LIMIT);
            won_d     = 1'b0;
            lost_d    = 1'b0;
            exact_d   = '0;
            partial_d = '0;
            clr_div   = 1'b1;
            state_d   = ST_PLAY;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            secret_q  <= '0;
            guess_q   <= '0;
            m_q       <= '0;
            u_q       <= '0;
            idx_q     <= '0;
            exact_q   <= '0;
            partial_q <= '0;
            tries_q   <= 4'(MAX_TRIES);
            time_q    <= TIME_W'(TIME_LIMIT);
            won_q     <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            secret_q  <= secret_d;
            guess_q   <= guess_d;
            m_q       <= m_d;
            u_q       <= u_d;
            idx_q     <= idx_d;
            exact_q   <= exact_d;
            partial_q <= partial_d;
            tries_q   <= tries_d;
            time_q    <= time_d;
            won_q     <= won_d;
            lost_q    <= lost_d;
        end
    end

    assign score_valid = (state_q == ST_REPORT);
    assign exact       = exact_q;
    assign partial     = partial_q;
    assign tries_left  = tries_q;
    assign time_left   = time_q;
    assign won         = won_q;
    assign lost        = lost_q;
    assign state       = state_q;

endmodule

// File: doc/mastermind_core.md
# mastermind_core

Parametrised game engine for the board-level Mastermind design: holds a secret code of SLOTS symbols, accepts guesses through a valid/ready handshake, and scores each guess with true Mastermind exact/partial peg counts, counting repeated symbols by multiplicity. It also enforces a guess budget and a countdown timer, and reports win/lose status. It sits between the switch/key capture logic and the HEX/LED display decoders, and replaces the per-slot comparator arrangement of the first-generation board.

## Interface
- SLOTS, 4, number of code positions (2..8)
- SYM_W, 4, bits per symbol
- MAX_TRIES, 10, guesses allowed per game (1..15)
- TIME_LIMIT, 99, countdown start value in ticks
- TICK_DIV, 50_000_000, CLOCK_50 cycles per countdown tick (≥2)
- CLOCK_50  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- load_secret  in  1  one-cycle strobe: capture secret, start new game
- secret  in  SLOTS*SYM_W  code; slot i = bits [i*SYM_W +: SYM_W]
- guess_valid  in  1  guess offered
- guess  in  SLOTS*SYM_W  guess, same packing as secret
- guess_ready  out  1  engine accepts a guess this cycle
- score_valid  out  1  one-cycle pulse, exact/partial valid
- exact  out  $clog2(SLOTS+1)  right symbol, right slot
- partial  out  $clog2(SLOTS+1)  right symbol, wrong slot (multiset, exact excluded)
- tries_left  out  4  remaining guesses
- time_left  out  $clog2(TIME_LIMIT+1)  remaining ticks
- won, lost  out  1 each  sticky game result
- state  out  3  FSM state, for debug LEDs

## Operation
- States: IDLE, PLAY, EXACT, MATCH, REPORT, WON, LOST.
- load_secret, in any state: latch secret, tries_left=MAX_TRIES, time_left=TIME_LIMIT, clear won/lost/exact/partial, reset tick divider, go to PLAY. It has priority over every other event in the same cycle; a simultaneous guess_valid is dropped.
- guess_ready = (state==PLAY) && time_left!=0 && !load_secret.
- Accept on guess_valid && guess_ready: latch guess, tries_left−1, go to EXACT.
- EXACT (1 cycle): compute exact mask m[i] = (guess[i]==secret[i]). exact = popcount(m). Clear the used-mask u.
- MATCH (SLOTS cycles, index i = 0..SLOTS−1): if !m[i], find the lowest j with !m[j] && !u[j] && secret[j]==guess[i]. If found, set u[j] and partial+1.
- REPORT (1 cycle): score_valid=1. Next state is WON if exact==SLOTS; else LOST if tries_left==0 or time_left==0; else PLAY.
- Timer: the tick divider pulses every TICK_DIV cycles. time_left decrements on a tick in PLAY/EXACT/MATCH/REPORT and saturates at 0. It is frozen in IDLE/WON/LOST.
- time_left reaching 0 in PLAY: go to LOST on the next cycle. Reaching 0 during EXACT/MATCH: scoring completes, then REPORT decides; a win has priority over timeout.
- WON/LOST are terminal until load_secret. exact/partial hold their last values there.

## Timing
- Reset values: state=IDLE, guess_ready=0, score_valid=0, exact=0, partial=0, tries_left=MAX_TRIES, time_left=TIME_LIMIT, won=0, lost=0, divider=0.
- Guess accepted at edge T. score_valid is high in the cycle after edge T+SLOTS+1, so latency = SLOTS+2 cycles.
- won or lost rises one cycle after the score_valid cycle. guess_ready re-rises one cycle after score_valid when play continues.
- exact/partial are cleared at acceptance and update during scoring; only the score_valid cycle is guaranteed final.
- Asynchronous reset mid-scoring aborts the guess; no score_valid is produced.

## Structure
- Package mastermind_pkg: state enum (3-bit encoding), count width functions, the default TICK_DIV constant.
- Sub-module tick_divider (parameter DIV): down-counter with synchronous clear, outputs a one-cycle tick. Replaces the ad-hoc rate divider.
- Packed-slot unpacking and the MATCH search are combinational inside mastermind_core. The priority search over j is a for loop.

## Test plan
Parameters for the bench: SLOTS=4, SYM_W=4, MAX_TRIES=3, TIME_LIMIT=5, TICK_DIV=4.
- Secret 1,2,3,4, guess 4,3,2,1 -> score_valid 6 cycles after accept, exact=0, partial=4, tries_left=2, back to PLAY.
- Secret 1,1,2,2, guess 1,2,1,1 -> exact=1, partial=2.
- Secret 7,7,7,7, guess 7,7,7,7 -> exact=4, partial=0, won=1; later guess_valid ignored with guess_ready=0.
- Three wrong guesses 0,0,0,0 against secret 1,2,3,4 -> tries_left 2,1,0, lost=1 after third REPORT.
- No guesses after load_secret -> time_left counts 5..0 every 4 cycles, lost=1 one cycle after reaching 0. Also: a correct guess whose MATCH spans the final tick -> won=1, lost=0.
- load_secret asserted together with guess_valid, and reset_n pulsed mid-MATCH -> guess dropped / no score_valid; outputs return to load or reset values.
